i2c_escravo_param: RTL and testbench
====================================

// Module: i2c_escravo_param
// PURPOSE
// Parametrised I2C target (slave), successor to the address-only decoder.
// Oversamples scl/sda on clk and detects START, repeated START and STOP.
// Matches a programmable ADDR_W-bit address, ACKs it, then receives or
// transmits up to MAX_BYTES data bytes per transfer. Sits between the
// open-drain pad (sda_oe pulls low) and the local register bank.
// PARAMETERS
// ADDR_W      7  target address width; only 7 is legal in this revision
// MAX_BYTES   16 data bytes ACKed per transfer; later writes NACKed
// SYNC_STAGES 2  synchroniser flops on scl and sda (>=2)
// PORTS
// clk               in  1      system clock, >= 8x scl frequency
// reset             in  1      synchronous, active-high
// scl               in  1      bus clock (raw pad)
// sda               in  1      bus data (raw pad)
// sda_oe            out 1      1 = pull sda low (ACK or tx bit 0)
// endereco_local    in  ADDR_W own address, sampled at each START
// pronto            in  1      local side ready; 0 -> NACK write data
// endereco_recebido out ADDR_W last address byte received, match or not
// operacao          out 1      R/W bit of last address (1 = read)
// escrita           out 1      1-clk pulse: dado_rx valid (write byte)
// dado_rx           out 8      received data byte
// dado_tx           in  8      byte to send, sampled on leitura pulse
// leitura           out 1      1-clk pulse: next tx byte loaded
// stop              out 1      1-clk pulse on STOP detection
// ocupado           out 1      1 while addressed (ACK_A to end)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, shift regs 0, byte counter 0.
// - scl/sda pass SYNC_STAGES flops; edges from last two synced samples.
// - START: sda fall while scl high; STOP: sda rise while scl high.
//   START in any state -> ADDR (repeated start), bit counter 0.
//   STOP in any state -> IDLE, sda_oe=0, stop pulse next clk.
// - Bits sampled on synced scl rising edge, MSB first.
// - sda_oe changes only on synced scl falling edge.
// - FSM: IDLE -> ADDR (8 bits) -> ACK_A | IGNORE.
//   ADDR: addr[6:0] == endereco_local -> ACK_A; else IGNORE.
//   endereco_recebido/operacao update at 8th rising edge either way.
//   ACK_A: sda_oe=1 one scl period; then RX if operacao=0, else TX.
//   RX: 8 bits -> ACK_D; escrita pulse + dado_rx at 8th rising edge.
//   ACK_D: ACK iff pronto=1 and count<MAX_BYTES, else NACK -> IGNORE.
//   Count increments only on ACKed byte.
//   TX: leitura pulse + dado_tx load on falling edge ending ACK_A or
//   MACK. sda_oe = ~bit each falling edge. After 8 bits -> MACK.
//   MACK: sample sda on rising edge; 0 -> TX; 1 (NACK) -> IGNORE.
//   IGNORE: sda_oe=0; wait for START or STOP.
// - ocupado = 1 from ACK_A entry to IDLE/IGNORE entry.
// - Count resets on every START. Bus glitch < 1 clk is not filtered.
// - sda edge with scl high inside a byte = START/STOP, abort byte.
// STRUCTURE
// - Package i2c_pkg: typedef enum estado_t {IDLE, ADDR, ACK_A, RX,
//   ACK_D, TX, MACK, IGNORE}; constants ADDR_BITS_7, BYTE_BITS=8.
// - Sub-module i2c_sincronizador: SYNC_STAGES flops + edge outputs
//   (scl_sobe, scl_desce, inicio, parada). One instance per block.
// - Top: FSM, 3-bit bit counter, byte counter, shift registers.
// TESTING
// - Local 7'h48, write 0x90, 0xA5, STOP
//   -> ACK both bytes; escrita x1, dado_rx=8'hA5; stop pulse.
// - Addr 7'h21 vs local 7'h48, write 0x42
//   -> endereco_recebido=7'h21; sda_oe never 1; IGNORE until STOP.
// - Read: dado_tx=8'h3C, addr 0x91, master NACK
//   -> leitura x1; sda pattern 00111100; IGNORE; stop.
// - pronto=0 during write byte 0x55 -> NACK on ACK_D; ocupado=0.
// - MAX_BYTES=2, write 3 bytes -> bytes 1-2 ACKed, byte 3 NACKed.
// - Repeated START after write byte, then addr 0x91 read
//   -> ADDR reentered, count cleared, TX; reset mid-TX -> outputs 0.

Source files
------------

// File: rtl/i2c_escravo_param_pkg.sv
// Shared types and constants for the parametrised I2C target.
// The helper shifts one sampled bus bit into a byte, MSB first.
package i2c_escravo_param_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        RX,
        ACK_D,
        TX,
        MACK,
        IGNORE
    } estado_t;

    localparam int ADDR_BITS_7 = 7;
    localparam int BYTE_BITS   = 8;

    function automatic logic [BYTE_BITS-1:0] desloca(input logic [BYTE_BITS-1:0] sr,
                                                     input logic                 b);
        return {sr[BYTE_BITS-2:0], b};
    endfunction

endpackage

// File: rtl/i2c_escravo_param_if.sv
// Pad side of the I2C target. sda is the resolved open-drain line;
// the target never drives it high, it only asserts sda_oe to pull it low.
interface i2c_escravo_param_if;

    logic scl;
    logic sda;
    logic sda_oe;

    modport master (output scl, output sda, input sda_oe);
    modport slave  (input scl, input sda, output sda_oe);

endinterface

// File: rtl/i2c_escravo_param_sincronizador.sv
// Synchronises raw scl/sda into clk and derives scl edges and START/STOP.
// Flops reset to 1 (idle bus level) so releasing reset never fakes an edge.
module i2c_escravo_param_sincronizador #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_sobe,
    output logic scl_desce,
    output logic inicio,
    output logic parada
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_sobe  = scl_s & ~scl_prev;
    assign scl_desce = ~scl_s & scl_prev;
    // sda may only move while scl is low; a move with scl held high is a bus condition
    assign inicio    = scl_s & scl_prev & sda_prev & ~sda_s;
    assign parada    = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_escravo_param.sv
// I2C target: address match, ACK, byte receive/transmit with a per-transfer
// byte limit. The FSM state is exported on 'estado' for observation.
module i2c_escravo_param
    import i2c_escravo_param_pkg::*;
#(
    parameter int ADDR_W      = ADDR_BITS_7,
    parameter int MAX_BYTES   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_escravo_param_if.slave   bus,
    input  logic [ADDR_W-1:0]    endereco_local,
    input  logic                 pronto,
    output logic [ADDR_W-1:0]    endereco_recebido,
    output logic                 operacao,
    output logic                 escrita,
    output logic [BYTE_BITS-1:0] dado_rx,
    input  logic [BYTE_BITS-1:0] dado_tx,
    output logic                 leitura,
    output logic                 stop,
    output logic                 ocupado,
    output estado_t              estado
);

    localparam int            CW    = $clog2(MAX_BYTES + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BYTES);

    logic sda_s, scl_sobe, scl_desce, inicio, parada;

    estado_t              estado_n;
    logic [2:0]           bit_cnt, bit_n;
    logic [CW-1:0]        byte_cnt, bytes_n;
    logic [BYTE_BITS-1:0] sr, sr_n, byte_in, rx_n;
    logic [ADDR_W-1:0]    local_q, local_n, end_n;
    logic                 fase, fase_n;
    logic                 oe_q, oe_n, op_n, ocup_n;
    logic                 escrita_n, leitura_n, stop_n;

    i2c_escravo_param_sincronizador #(.SYNC_STAGES(SYNC_STAGES)) u_sinc (
        .clk       (clk),
        .reset     (reset),
        .scl       (bus.scl),
        .sda       (bus.sda),
        .sda_s     (sda_s),
        .scl_sobe  (scl_sobe),
        .scl_desce (scl_desce),
        .inicio    (inicio),
        .parada    (parada)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado            <= IDLE;
            bit_cnt           <= '0;
            byte_cnt          <= '0;
            sr                <= '0;
            local_q           <= '0;
            fase              <= 1'b0;
            oe_q              <= 1'b0;
            endereco_recebido <= '0;
            operacao          <= 1'b0;
            dado_rx           <= '0;
            ocupado           <= 1'b0;
            escrita           <= 1'b0;
            leitura           <= 1'b0;
            stop              <= 1'b0;
        end else begin
            estado            <= estado_n;
            bit_cnt           <= bit_n;
            byte_cnt          <= bytes_n;
            sr                <= sr_n;
            local_q           <= local_n;
            fase              <= fase_n;
            oe_q              <= oe_n;
            endereco_recebido <= end_n;
            operacao          <= op_n;
            dado_rx           <= rx_n;
            ocupado           <= ocup_n;
            escrita           <= escrita_n;
            leitura           <= leitura_n;
            stop              <= stop_n;
        end
    end

    assign bus.sda_oe = oe_q;

    // 'fase' splits the two-edge states: ACK_A/ACK_D drive on the first scl
    // fall and release on the second; MACK remembers the master's ACK.
    always_comb begin
        estado_n  = estado;
        bit_n     = bit_cnt;
        bytes_n   = byte_cnt;
        sr_n      = sr;
        local_n   = local_q;
        fase_n    = fase;
        oe_n      = oe_q;
        end_n     = endereco_recebido;
        op_n      = operacao;
        rx_n      = dado_rx;
        ocup_n    = ocupado;
        escrita_n = 1'b0;
        leitura_n = 1'b0;
        stop_n    = 1'b0;
        byte_in   = desloca(sr, sda_s);

        if (parada) begin
            estado_n = IDLE;
            oe_n     = 1'b0;
            ocup_n   = 1'b0;
            stop_n   = 1'b1;
        end else if (inicio) begin
            estado_n = ADDR;
            bit_n    = '0;
            bytes_n  = '0;
            sr_n     = '0;
            fase_n   = 1'b0;
            oe_n     = 1'b0;
            local_n  = endereco_local;
        end else begin
            case (estado)
                ADDR: if (scl_sobe) begin
                    sr_n  = byte_in;
                    bit_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        end_n  = byte_in[BYTE_BITS-1 -: ADDR_W];
                        op_n   = byte_in[0];
                        fase_n = 1'b0;
                        if (byte_in[BYTE_BITS-1 -: ADDR_W] == local_q) begin
                            estado_n = ACK_A;
                            ocup_n   = 1'b1;
                        end else begin
                            estado_n = IGNORE;
                            ocup_n   = 1'b0;
                        end
                    end
                end
                ACK_A: if (scl_desce) begin
                    if (!fase) begin
                        oe_n   = 1'b1;
                        fase_n = 1'b1;
                    end else begin
                        fase_n = 1'b0;
                        bit_n  = '0;
                        if (operacao) begin
                            estado_n  = TX;
                            sr_n      = dado_tx;
                            oe_n      = ~dado_tx[BYTE_BITS-1];
                            leitura_n = 1'b1;
                        end else begin
                            estado_n = RX;
                            oe_n     = 1'b0;
                        end
                    end
                end
                RX: if (scl_sobe) begin
                    sr_n  = byte_in;
                    bit_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_n      = byte_in;
                        escrita_n = 1'b1;
                        estado_n  = ACK_D;
                        fase_n    = 1'b0;
                    end
                end
                ACK_D: if (scl_desce) begin
                    if (!fase) begin
                        if (pronto && (byte_cnt < MAX_C)) begin
                            oe_n    = 1'b1;
                            fase_n  = 1'b1;
                            bytes_n = byte_cnt + CW'(1);
                        end else begin
                            estado_n = IGNORE;
                            oe_n     = 1'b0;
                            ocup_n   = 1'b0;
                        end
                    end else begin
                        estado_n = RX;
                        oe_n     = 1'b0;
                        fase_n   = 1'b0;
                        bit_n    = '0;
                    end
                end
                TX: if (scl_desce) begin
                    if (bit_cnt == 3'd7) begin
                        estado_n = MACK;
                        oe_n     = 1'b0;
                        fase_n   = 1'b0;
                    end else begin
                        oe_n  = ~sr[BYTE_BITS-2];
                        sr_n  = {sr[BYTE_BITS-2:0], 1'b0};
                        bit_n = bit_cnt + 3'd1;
                    end
                end
                MACK: begin
                    if (scl_sobe && !fase) begin
                        if (sda_s) begin
                            estado_n = IGNORE;
                            ocup_n   = 1'b0;
                        end else begin
                            fase_n = 1'b1;
                        end
                    end else if (scl_desce && fase) begin
                        estado_n  = TX;
                        fase_n    = 1'b0;
                        bit_n     = '0;
                        sr_n      = dado_tx;
                        oe_n      = ~dado_tx[BYTE_BITS-1];
                        leitura_n = 1'b1;
                    end
                end
                IGNORE: oe_n = 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_escravo_param.sv
// Bench for i2c_escravo_param: a bit-level bus master, a transaction-level
// reference model (address match, byte limit, pronto) and pulse monitors.
module tb_i2c_escravo_param;
    import i2c_escravo_param_pkg::*;

    localparam int MAX_B = 2;
    localparam int Q     = 50;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       scl_m, sda_m;
    logic [6:0] loc_addr;
    logic       pronto;
    logic [6:0] endereco_recebido;
    logic       operacao, escrita, leitura, stop, ocupado;
    logic [7:0] dado_rx, dado_tx;
    estado_t    estado;

    i2c_escravo_param_if bif();
    assign bif.scl = scl_m;
    assign bif.sda = sda_m & ~bif.sda_oe;

    i2c_escravo_param #(.ADDR_W(7), .MAX_BYTES(MAX_B), .SYNC_STAGES(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bif.slave),
        .endereco_local    (loc_addr),
        .pronto            (pronto),
        .endereco_recebido (endereco_recebido),
        .operacao          (operacao),
        .escrita           (escrita),
        .dado_rx           (dado_rx),
        .dado_tx           (dado_tx),
        .leitura           (leitura),
        .stop              (stop),
        .ocupado           (ocupado),
        .estado            (estado)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] txq[$];
    logic [7:0] tx_tab[256];
    logic [7:0] tx_idx = '0;
    logic [7:0] mon_e;
    int esc_cnt = 0, lei_cnt = 0, stop_cnt = 0, oe_cnt = 0;
    logic [7:0] wdata[8];
    logic       wpronto[8];

    assign dado_tx = tx_tab[tx_idx];

    always @(negedge clk) begin
        if (!reset) begin
            if (escrita) begin
                esc_cnt++;
                if (exp_q.size() == 0) begin
                    check("escrita_spur", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dado_rx", dado_rx, mon_e);
                end
            end
            if (leitura) begin
                lei_cnt++;
                txq.push_back(dado_tx);
                tx_idx++;
            end
            if (stop) stop_cnt++;
            if (bif.sda_oe) oe_cnt++;
        end
    end

    // driver tasks
    task automatic write_bit(input logic b);
        sda_m = b;    #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = bif.sda;  #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic start_cond();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
    endtask

    task automatic read_byte(output logic [7:0] b);
        logic x;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            read_bit(x);
            b = {b[6:0], x};
        end
    endtask

    // One transfer against the reference model: target acknowledges its own
    // address; write byte i is ACKed iff pronto and i < MAX_B; reads return
    // the bytes the bench presented on dado_tx, in order.
    task automatic transfer(input logic [6:0] a, input logic rw, input int n, input logic rep);
        logic       hit, ackb, exp_ack, last;
        logic [7:0] b, e;
        int esc0, lei0, st0, oe0, sent;
        hit  = (a == loc_addr);
        esc0 = esc_cnt; lei0 = lei_cnt; st0 = stop_cnt; oe0 = oe_cnt;
        sent = 0;
        start_cond();
        send_byte({a, rw});
        read_bit(ackb);
        check("ack_addr", ackb, !hit);
        check("end_rec", endereco_recebido, a);
        check("operacao", operacao, rw);
        check("ocupado_addr", ocupado, hit);
        if (!rw) begin
            for (int i = 0; i < n; i++) begin
                pronto = wpronto[i];
                if (hit) begin
                    exp_q.push_back(wdata[i]);
                    sent++;
                end
                send_byte(wdata[i]);
                read_bit(ackb);
                exp_ack = hit && wpronto[i] && (i < MAX_B);
                check("ack_data", ackb, !exp_ack);
                if (!exp_ack) begin
                    check("ocupado_nack", ocupado, 1'b0);
                    break;
                end
            end
            pronto = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                read_byte(b);
                last = (i == n - 1) || !hit;
                if (hit) begin
                    if (txq.size() == 0) begin
                        check("leitura_missing", 32'd0, 32'd1);
                    end else begin
                        e = txq.pop_front();
                        check("rd_byte", b, e);
                    end
                end else begin
                    check("rd_idle", b, 8'hFF);
                end
                write_bit(last);
                if (last) break;
            end
        end
        check("escritas", esc_cnt - esc0, (hit && !rw) ? sent : 0);
        check("leituras", lei_cnt - lei0, (hit && rw) ? n : 0);
        if (!hit) check("oe_unaddressed", oe_cnt - oe0, 0);
        if (!rep) begin
            stop_cond();
            check("stop_pulse", stop_cnt - st0, 1);
            check("ocupado_end", ocupado, 1'b0);
            check("estado_end", estado, IDLE);
        end
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ackb, xb;
        for (int i = 0; i < 256; i++) tx_tab[i] = 8'($urandom_range(0, 255));
        tx_tab[0] = 8'h3C;
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; pronto = 1'b1; loc_addr = 7'h48;
        repeat (5) @(posedge clk);
        #2;
        check("rst_oe", bif.sda_oe, 1'b0);
        check("rst_ocupado", ocupado, 1'b0);
        check("rst_pulses", {escrita, leitura, stop}, 3'b000);
        check("rst_dados", {endereco_recebido, operacao, dado_rx}, 16'h0);
        check("rst_estado", estado, IDLE);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        // write 0x90, 0xA5
        wdata[0] = 8'hA5; wpronto[0] = 1'b1;
        transfer(7'h48, 1'b0, 1, 1'b0);
        // foreign address
        wdata[0] = 8'h42;
        transfer(7'h21, 1'b0, 1, 1'b0);
        // read 0x91 returns 0x3C, master NACK
        transfer(7'h48, 1'b1, 1, 1'b0);
        // pronto low during data byte
        wdata[0] = 8'h55; wpronto[0] = 1'b0;
        transfer(7'h48, 1'b0, 1, 1'b0);
        // byte limit
        for (int i = 0; i < 3; i++) begin wdata[i] = 8'(8'h10 + i); wpronto[i] = 1'b1; end
        transfer(7'h48, 1'b0, 3, 1'b0);
        // repeated STARTs: the counter restarts each time
        transfer(7'h48, 1'b0, 2, 1'b1);
        transfer(7'h48, 1'b0, 2, 1'b1);
        transfer(7'h48, 1'b1, 2, 1'b0);

        for (int t = 0; t < 30; t++) begin
            logic [6:0] a;
            if ($urandom_range(0, 4) == 0) loc_addr = 7'($urandom_range(0, 127));
            a = ($urandom_range(0, 3) != 0) ? loc_addr : 7'($urandom_range(0, 127));
            for (int i = 0; i < 8; i++) begin
                wdata[i]   = 8'($urandom_range(0, 255));
                wpronto[i] = ($urandom_range(0, 9) != 0);
            end
            transfer(a, 1'($urandom_range(0, 1)), $urandom_range(1, 4),
                     ($urandom_range(0, 3) == 0));
        end

        // reset in the middle of a read byte
        loc_addr = 7'h48;
        start_cond();
        send_byte({7'h48, 1'b1});
        read_bit(ackb);
        check("mid_ack", ackb, 1'b0);
        for (int i = 0; i < 3; i++) read_bit(xb);
        check("mid_ocupado", ocupado, 1'b1);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("mid_rst_oe", bif.sda_oe, 1'b0);
        check("mid_rst_ocupado", ocupado, 1'b0);
        check("mid_rst_pulses", {escrita, leitura, stop}, 3'b000);
        check("mid_rst_dados", {endereco_recebido, operacao, dado_rx}, 16'h0);
        check("mid_rst_estado", estado, IDLE);
        txq.delete();
        sda_m = 1'b1; scl_m = 1'b1;
        #20;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("post_rst_estado", estado, IDLE);
        check("post_rst_oe", bif.sda_oe, 1'b0);

        check("exp_q_empty", exp_q.size(), 0);
        check("txq_empty", txq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
